// File: rtl/puzzle_pkg.sv
// rtl/puzzle_pkg.sv - shared types, LFSR taps and direction helper for the sliding-puzzle engine
package puzzle_pkg;

    // Direction the EMPTY cell travels.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_MOVE = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Right-shifting Galois LFSR feedback mask (maximal length).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic dir_t inverse_dir(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            default:   return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR
//   clk   : system clock
//   reset : asynchronous active-high reset, loads seed
//   seed  : reset value (must be nonzero)
//   q     : current LFSR state, advances every cycle
module lfsr16
    import puzzle_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= seed;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/puzzle_scrambler.sv
// rtl/puzzle_scrambler.sv - NxN sliding-puzzle board with LFSR scrambler and player moves
//   Optional feature macro: NO_BACKTRACK_EN (scrambler never undoes its previous move)
//   clk, reset         : clock, asynchronous active-high reset
//   start              : request a new scramble (taken in S_IDLE only, wins over move_valid)
//   move_valid/dir     : player move of the empty cell (taken in S_IDLE only)
//   rd_addr/rd_data    : combinational tile read port, row-major, 0 = empty
//   empty_pos          : index of the empty cell
//   busy/done/move_ok  : registered status; done and move_ok are one-cycle pulses
//   solved             : board equals the solved layout
module puzzle_scrambler
    import puzzle_pkg::*;
#(
    parameter int          N         = 4,
    parameter int          MOVES     = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         CW        = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          move_valid,
    input  logic [1:0]    move_dir,
    input  logic [CW-1:0] rd_addr,
    output logic [CW-1:0] rd_data,
    output logic [CW-1:0] empty_pos,
    output logic          busy,
    output logic          done,
    output logic          move_ok,
    output logic          solved
);

    localparam int TILES = N * N;
    localparam int CTW   = $clog2(MOVES + 1);

    logic [CW-1:0]  board [TILES];
    state_t         state;
    logic [CTW-1:0] cnt;
    logic [15:0]    lfsr_q;
    logic           lfsr_unused;

`ifdef NO_BACKTRACK_EN
    dir_t           last_dir;
    logic           last_valid;
`endif

    dir_t           p_dir;
    logic           p_ok;
    logic [CW-1:0]  p_nbr;
    dir_t           c_dir;
    logic           c_ok;
    logic [CW-1:0]  c_nbr;

    function automatic logic [CW-1:0] solved_tile(input int i);
        return (i < TILES - 1) ? CW'(i + 1) : '0;
    endfunction

    function automatic logic edge_legal(input logic [CW-1:0] pos, input dir_t d);
        int r;
        int c;
        r = int'(pos) / N;
        c = int'(pos) % N;
        case (d)
            DIR_UP:    return (r > 0);
            DIR_DOWN:  return (r < N - 1);
            DIR_LEFT:  return (c > 0);
            default:   return (c < N - 1);
        endcase
    endfunction

    // Only meaningful when edge_legal() holds for the same (pos, d).
    function automatic logic [CW-1:0] nbr_idx(input logic [CW-1:0] pos, input dir_t d);
        case (d)
            DIR_UP:    return CW'(int'(pos) - N);
            DIR_DOWN:  return CW'(int'(pos) + N);
            DIR_LEFT:  return CW'(int'(pos) - 1);
            default:   return CW'(int'(pos) + 1);
        endcase
    endfunction

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Only the two low bits pick the candidate direction.
    assign lfsr_unused = ^lfsr_q[15:2];

    always_comb begin
        p_dir = dir_t'(move_dir);
        p_ok  = edge_legal(empty_pos, p_dir);
        p_nbr = nbr_idx(empty_pos, p_dir);
        c_dir = dir_t'(lfsr_q[1:0]);
        c_nbr = nbr_idx(empty_pos, c_dir);
`ifdef NO_BACKTRACK_EN
        c_ok  = edge_legal(empty_pos, c_dir) &&
                !(last_valid && (c_dir == inverse_dir(last_dir)));
`else
        c_ok  = edge_legal(empty_pos, c_dir);
`endif
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < TILES) begin
            rd_data = board[rd_addr];
        end
    end

    always_comb begin
        solved = 1'b1;
        for (int i = 0; i < TILES; i++) begin
            if (board[i] != solved_tile(i)) begin
                solved = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TILES; i++) begin
                board[i] <= solved_tile(i);
            end
            empty_pos <= CW'(TILES - 1);
            state     <= S_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            move_ok   <= 1'b0;
`ifdef NO_BACKTRACK_EN
            last_dir   <= DIR_UP;
            last_valid <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            move_ok <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_INIT;
                        busy  <= 1'b1;
                    end else if (move_valid && p_ok) begin
                        // The empty cell always holds 0, so the swap is a copy plus a clear.
                        board[empty_pos] <= board[p_nbr];
                        board[p_nbr]     <= '0;
                        empty_pos        <= p_nbr;
                        move_ok          <= 1'b1;
                    end
                end
                S_INIT: begin
                    for (int i = 0; i < TILES; i++) begin
                        board[i] <= solved_tile(i);
                    end
                    empty_pos <= CW'(TILES - 1);
                    cnt       <= '0;
`ifdef NO_BACKTRACK_EN
                    last_valid <= 1'b0;
`endif
                    state     <= S_MOVE;
                end
                S_MOVE: begin
                    if (cnt == CTW'(MOVES)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (c_ok) begin
                        board[empty_pos] <= board[c_nbr];
                        board[c_nbr]     <= '0;
                        empty_pos        <= c_nbr;
                        cnt              <= cnt + CTW'(1);
`ifdef NO_BACKTRACK_EN
                        last_dir   <= c_dir;
                        last_valid <= 1'b1;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
